// File: rtl/tff_ctrl_pkg.sv
// Shared types for the TFF bank counting controller.
package tff_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/tff_bank.sv
// Bank of toggle cells: each bit flips on the edge where its toggle enable is high.
module tff_bank #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] q
);

    // Each cell is a D flop fed with q ^ t, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else        q <= q ^ t;
    end

endmodule

// File: rtl/tff_count_ctrl.sv
// Sequencing controller that drives a TFF bank as a loadable up/down counter
// terminating at a latched limit.
// Build option: TFF_COUNT_CTRL_RELOAD_EN -- when defined, reaching the limit
// reloads the latched start value and keeps running instead of stopping in DONE.
//
//  state | meaning
//  IDLE  | bank holds, waiting for start
//  RUN   | bank steps one count per edge toward limit_r
//  DONE  | limit reached, bank holds at limit_r until the next start
module tff_count_ctrl
    import tff_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic [WIDTH-1:0] init_val,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic [WIDTH-1:0] limit_r;
    logic             dir_r;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] up_t;
    logic [WIDTH-1:0] dn_t;
    logic [WIDTH-1:0] lo_mask;
    logic             hit;
`ifdef TFF_COUNT_CTRL_RELOAD_EN
    // Start value is only needed again when the limit triggers a reload.
    logic [WIDTH-1:0] init_r;
`endif

    tff_bank #(.WIDTH(WIDTH)) u_bank (
        .clk   (clk),
        .rst_n (rst_n),
        .t     (t),
        .q     (q)
    );

    // Ripple-carry toggle patterns: bit i flips when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        up_t    = '0;
        dn_t    = '0;
        lo_mask = '0;
        up_t[0] = 1'b1;
        dn_t[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            lo_mask = WIDTH'((1 << i) - 1);
            up_t[i] = ((q & lo_mask) == lo_mask);
            dn_t[i] = ((q & lo_mask) == '0);
        end
    end

    // Toggle vector in priority order stop > start > terminal > step; loads flip only differing bits.
    always_comb begin
        t   = '0;
        hit = 1'b0;
        if (stop) begin
            t = '0;
        end else if (start) begin
            t = q ^ init_val;
        end else if (state == RUN) begin
            if (q == limit_r) begin
                hit = 1'b1;
`ifdef TFF_COUNT_CTRL_RELOAD_EN
                t = q ^ init_r;
`else
                t = '0;
`endif
            end else begin
                case (dir_r)
                    DIR_UP:  t = up_t;
                    DIR_DN:  t = dn_t;
                    default: t = '0;
                endcase
            end
        end
    end

    // FSM, start-time latches and registered busy/done flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            limit_r <= '0;
            dir_r   <= DIR_DN;
`ifdef TFF_COUNT_CTRL_RELOAD_EN
            init_r  <= '0;
`endif
        end else begin
            done <= hit;
            if (stop) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else if (start) begin
                state   <= RUN;
                busy    <= 1'b1;
                limit_r <= limit;
                dir_r   <= dir;
`ifdef TFF_COUNT_CTRL_RELOAD_EN
                init_r  <= init_val;
`endif
            end else if (hit) begin
`ifdef TFF_COUNT_CTRL_RELOAD_EN
                state <= RUN;
                busy  <= 1'b1;
`else
                state <= DONE;
                busy  <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Self-checking bench for tff_count_ctrl (WIDTH=4): vector table, hand-written
// corner sequences, then randomized traffic against a behavioural model.
module tb_tff_count_ctrl;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start, stop, dir;
    logic [W-1:0] init_val, limit;
    logic [W-1:0] q;
    logic         busy, done;

    int total = 0;
    int bad   = 0;

    // behavioural model state
    int unsigned mq, ml, mi;
    bit          md, mrun, mdone;

    typedef struct {
        bit       start;
        bit       stop;
        bit       dir;
        int       init;
        int       lim;
        int       exp_q;
        bit       exp_busy;
        bit       exp_done;
    } vec_t;

    vec_t vecs[9];

    tff_count_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .dir      (dir),
        .init_val (init_val),
        .limit    (limit),
        .q        (q),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        mq = 0; ml = 0; mi = 0; md = 0; mrun = 0; mdone = 0;
    endtask

    // One clock edge of the counter, from the written rules.
    task automatic model_edge();
        mdone = 0;
        if (stop) begin
            mrun = 0;
        end else if (start) begin
            mq = init_val; ml = limit; mi = init_val; md = dir; mrun = 1;
        end else if (mrun) begin
            if (mq == ml) begin
                mdone = 1;
`ifdef TFF_COUNT_CTRL_RELOAD_EN
                mq = mi;
`else
                mrun = 0;
`endif
            end else if (md) begin
                mq = (mq + 1) % MOD;
            end else begin
                mq = (mq + MOD - 1) % MOD;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_in();
        start = 0; stop = 0;
    endtask

    task automatic go(input int iv, input int lv, input bit d);
        start = 1; stop = 0; dir = d; init_val = W'(iv); limit = W'(lv);
    endtask

    task automatic chk3(input string nm, input int eq, input int eb, input int ed);
        chk({nm, ".q"}, int'(q), eq);
        chk({nm, ".busy"}, int'(busy), eb);
        chk({nm, ".done"}, int'(done), ed);
    endtask

    initial begin
        vecs[0] = '{1, 0, 1,  3,  7,  3, 1, 0};
        vecs[1] = '{0, 0, 1,  3,  7,  4, 1, 0};
        vecs[2] = '{0, 0, 0,  9,  2,  5, 1, 0};
        vecs[3] = '{1, 1, 0, 12,  0,  5, 0, 0};
        vecs[4] = '{0, 0, 1,  0,  0,  5, 0, 0};
        vecs[5] = '{1, 0, 0,  1, 14,  1, 1, 0};
        vecs[6] = '{0, 0, 0,  1, 14,  0, 1, 0};
        vecs[7] = '{0, 0, 0,  1, 14, 15, 1, 0};
        vecs[8] = '{0, 0, 0,  1, 14, 14, 1, 0};

        rst_n = 0; start = 0; stop = 0; dir = 0; init_val = '0; limit = '0;
        model_reset();
        #1;
        chk3("reset", 0, 0, 0);
        #11 rst_n = 1;

        // table: load, step, ignored inputs, start+stop, down with wrap
        for (int i = 0; i < 9; i++) begin
            start = vecs[i].start; stop = vecs[i].stop; dir = vecs[i].dir;
            init_val = W'(vecs[i].init); limit = W'(vecs[i].lim);
            step();
            chk3($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_busy, vecs[i].exp_done);
        end
        idle_in();
        step();
`ifdef TFF_COUNT_CTRL_RELOAD_EN
        chk3("down_term", 1, 1, 1);
`else
        chk3("down_term", 14, 0, 1);
        step();
        chk3("down_after", 14, 0, 0);
`endif

        // terminal sequence on an up count
`ifdef TFF_COUNT_CTRL_RELOAD_EN
        go(2, 4, 1);
        step();
        idle_in();
        for (int k = 0; k < 10; k++) begin
            if (k > 0) step();
            chk3($sformatf("reload%0d", k), 2 + (k % 3), 1, (k > 0 && k % 3 == 0) ? 1 : 0);
        end
`else
        go(3, 7, 1);
        step();
        idle_in();
        for (int k = 0; k < 11; k++) begin
            if (k > 0) step();
            chk3($sformatf("up%0d", k), (k < 5) ? 3 + k : 7, (k <= 4) ? 1 : 0, (k == 5) ? 1 : 0);
        end
`endif

        // mid-cycle reset with q nonzero
        chk("pre_rst_nz", (q != 0) ? 1 : 0, 1);
        #2 rst_n = 0;
        model_reset();
        #1;
        chk3("midrst", 0, 0, 0);
        #4 rst_n = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk3($sformatf("postrst%0d", k), 0, 0, 0);
        end

        // reset during RUN at q=6, then equal init/limit
        go(4, 12, 1);
        step();
        idle_in();
        step();
        step();
        chk3("run6", 6, 1, 0);
        #2 rst_n = 0;
        model_reset();
        #1;
        chk3("runrst", 0, 0, 0);
        #4 rst_n = 1;
        go(9, 9, 0);
        step();
        idle_in();
        chk3("eq_load", 9, 1, 0);
        step();
`ifdef TFF_COUNT_CTRL_RELOAD_EN
        chk3("eq_term", 9, 1, 1);
`else
        chk3("eq_term", 9, 0, 1);
`endif

        // randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            start    = ($urandom_range(0, 19) == 0);
            stop     = ($urandom_range(0, 39) == 0);
            dir      = 1'($urandom_range(0, 1));
            init_val = W'($urandom_range(0, MOD - 1));
            limit    = W'($urandom_range(0, MOD - 1));
            step();
            chk3($sformatf("rnd%0d", n), int'(mq), int'(mrun), int'(mdone));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
